// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input sync, 3-sample mid-bit majority vote,
// parity/framing/break/overrun detection, and a valid/ready output FIFO.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_rx,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int MID   = (CLK_PER_BIT - 1) / 2;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] C_MID_M1   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] C_MID      = CNT_W'(MID);
  localparam logic [CNT_W-1:0] C_MID_P1   = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic             C_LAST_STP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_s0;
  logic                 r_s1;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pbit;
  logic                 r_ferr;
  logic                 r_break;
  logic                 r_overrun;
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];

  logic          w_rx;
  logic          w_vote;
  logic          w_decide;
  logic          w_wrap;
  logic          w_par_x;
  logic          w_perr;
  logic          w_last_stop;
  logic          w_frame_err;
  logic          w_is_break;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_overrun;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign w_rx     = r_sync2;
  assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_decide = (r_cnt == C_MID_P1);
  assign w_wrap   = (r_cnt == C_LAST);

  always_comb begin
    w_par_x = (^r_shift) ^ r_pbit;
    w_perr  = 1'b0;
    if (PARITY == 1) begin
      w_perr = w_par_x;
    end else if (PARITY == 2) begin
      w_perr = ~w_par_x;
    end
  end

  // The frame is closed at the vote of the last stop bit, not at its end,
  // so a start bit arriving right after the stop bit is never missed.
  assign w_last_stop = (r_state == S_STOP) && w_decide && (r_stop_idx == C_LAST_STP);
  assign w_frame_err = r_ferr | ~w_vote;
  assign w_is_break  = (r_shift == '0) && !r_pbit && w_frame_err;
  assign w_push_req  = w_last_stop && !w_is_break;
  assign w_entry     = {w_frame_err, w_perr, r_shift};

  assign o_valid = (r_wr_ptr != r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = o_valid && i_ready;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_overrun = w_push_req && w_full && !w_pop;

  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign o_data       = o_valid ? w_head[DATA_BITS-1:0] : '0;
  assign o_parity_err = o_valid & w_head[DATA_BITS];
  assign o_frame_err  = o_valid & w_head[DATA_BITS+1];
  assign o_break      = r_break;
  assign o_overrun    = r_overrun;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) w_state_next = S_START;
      end
      S_START: begin
        if (w_decide && w_vote) begin
          w_state_next = S_IDLE;
        end else if (w_wrap) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_wrap && (r_bit_idx == C_LAST_BIT)) begin
          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_wrap) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_last_stop) w_state_next = w_frame_err ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        if (w_rx) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_pbit     <= 1'b0;
      r_ferr     <= 1'b0;
      r_break    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_break   <= w_last_stop && w_is_break;
      r_overrun <= w_overrun;
      if (r_state == S_IDLE || w_wrap || w_state_next == S_IDLE || w_state_next == S_WAIT_HIGH) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt == C_MID_M1) r_s0 <= w_rx;
      if (r_cnt == C_MID) r_s1 <= w_rx;
      case (r_state)
        S_IDLE: begin
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
          r_ferr     <= 1'b0;
          r_pbit     <= 1'b0;
        end
        S_DATA: begin
          if (w_decide) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_wrap) r_bit_idx <= r_bit_idx + 1'b1;
        end
        S_PARITY: begin
          if (w_decide) r_pbit <= w_vote;
        end
        S_STOP: begin
          if (w_decide && !w_vote) r_ferr <= 1'b1;
          if (w_wrap) r_stop_idx <= r_stop_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head fields are masked until an entry is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations (8E1, 8O1, 7N2)
// checked against a frame-level model with an expected-entry queue per receiver.
module tb_uart_rx_param;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [2:0] rdy = 3'b111;

  logic       valid_a, perr_a, ferr_a, brk_a, ovr_a;
  logic [7:0] data_a;
  logic       valid_b, perr_b, ferr_b, brk_b, ovr_b;
  logic [6:0] data_b;
  logic       valid_c, perr_c, ferr_c, brk_c, ovr_c;
  logic [7:0] data_c;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
    .clock(clk), .reset_n(reset_n), .i_rx(rx_a), .o_valid(valid_a), .i_ready(rdy[0]),
    .o_data(data_a), .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_break(brk_a), .o_overrun(ovr_a)
  );

  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
    .clock(clk), .reset_n(reset_n), .i_rx(rx_b), .o_valid(valid_b), .i_ready(rdy[1]),
    .o_data(data_b), .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_break(brk_b), .o_overrun(ovr_b)
  );

  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_c (
    .clock(clk), .reset_n(reset_n), .i_rx(rx_a), .o_valid(valid_c), .i_ready(rdy[2]),
    .o_data(data_c), .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_break(brk_c), .o_overrun(ovr_c)
  );

  // Entry encoding used everywhere: bit10 = frame_err, bit9 = parity_err, low bits = data.
  logic [31:0] got [3];
  logic [2:0]  w_valid, w_brk, w_ovr;
  assign got[0]  = 32'({ferr_a, perr_a, 1'b0, data_a});
  assign got[1]  = 32'({ferr_b, perr_b, 2'b00, data_b});
  assign got[2]  = 32'({ferr_c, perr_c, 1'b0, data_c});
  assign w_valid = {valid_c, valid_b, valid_a};
  assign w_brk   = {brk_c, brk_b, brk_a};
  assign w_ovr   = {ovr_c, ovr_b, ovr_a};

  int n_checks = 0;
  int n_pass   = 0;
  int q [3][$];
  int exp_brk [3] = '{0, 0, 0};
  int exp_ovr [3] = '{0, 0, 0};
  int cnt_brk [3] = '{0, 0, 0};
  int cnt_ovr [3] = '{0, 0, 0};
  int last    [3] = '{-1, -1, -1};
  int npop    [3] = '{0, 0, 0};
  int prev_got [3] = '{0, 0, 0};
  bit prev_hold [3] = '{0, 0, 0};

  task automatic check(input string name, input int g, input int e);
    n_checks++;
    if (g == e) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, g, e);
  endtask

  // Frame-level model: derive the entry (or break / overrun) from what was put on the line.
  task automatic frame_model(input int i, input int d, input int pm, input bit pb, input bit fe);
    bit perr;
    bit brk;
    perr = (pm == 0) ? 1'b0 : (bit'($countones(d) & 1) ^ pb ^ (pm == 2));
    brk  = (d == 0) && (pm == 0 || !pb) && fe;
    if (brk) exp_brk[i]++;
    else if (q[i].size() >= DEPTH && !rdy[i]) exp_ovr[i]++;
    else q[i].push_back((int'(fe) << 10) | (int'(perr) << 9) | d);
  endtask

  // Outputs are sampled just after the falling edge, i.e. the values the next rising edge will see.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) prev_hold[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (prev_hold[i]) check($sformatf("hold%0d", i), w_valid[i] ? int'(got[i]) : -1, prev_got[i]);
        if (w_valid[i] && rdy[i]) begin
          if (q[i].size() == 0) begin
            check($sformatf("unexpected_entry%0d", i), int'(got[i]), -1);
          end else begin
            check($sformatf("pop%0d", i), int'(got[i]), q[i][0]);
            void'(q[i].pop_front());
          end
          last[i] = int'(got[i]);
          npop[i]++;
        end
        prev_hold[i] = w_valid[i] && !rdy[i];
        prev_got[i]  = int'(got[i]);
        if (w_brk[i]) cnt_brk[i]++;
        if (w_ovr[i]) cnt_ovr[i]++;
      end
    end
  end

  task automatic put(input bit line, input bit v);
    if (line) rx_b = v;
    else rx_a = v;
  endtask

  task automatic hold_bit(input bit line, input bit v, input bit glitch);
    put(line, v);
    if (glitch) begin
      repeat (CPB / 2) @(negedge clk);
      put(line, ~v);
      @(negedge clk);
      put(line, v);
      repeat (CPB / 2 - 1) @(negedge clk);
    end else begin
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_a(input int d, input bit pb, input bit stop, input int gbit);
    frame_model(0, d, 1, pb, !stop);
    frame_model(2, d, 2, pb, !stop);
    hold_bit(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) hold_bit(1'b0, bit'(d >> k), k == gbit);
    hold_bit(1'b0, pb, 1'b0);
    hold_bit(1'b0, stop, 1'b0);
    put(1'b0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_b(input int d, input bit s1, input bit s2);
    frame_model(1, d, 0, 1'b0, !(s1 && s2));
    hold_bit(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) hold_bit(1'b1, bit'(d >> k), 1'b0);
    hold_bit(1'b1, s1, 1'b0);
    hold_bit(1'b1, s2, 1'b0);
    put(1'b1, 1'b1);
    repeat (3 * CPB) @(negedge clk);
  endtask

  function automatic bit even_pb(input int d);
    return bit'($countones(d) & 1);
  endfunction

  initial begin
    int n0;
    repeat (4) @(negedge clk);
    check("reset_a", int'({valid_a, brk_a, ovr_a, perr_a, ferr_a, data_a}), 0);
    check("reset_b", int'({valid_b, brk_b, ovr_b, perr_b, ferr_b, data_b}), 0);
    check("reset_c", int'({valid_c, brk_c, ovr_c, perr_c, ferr_c, data_c}), 0);
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // T1: 0xA5 with parity bit 0
    send_a(8'hA5, 1'b0, 1'b1, -1);
    check("t1_even_entry", last[0], 'h0A5);
    check("t1_odd_entry", last[2], 'h2A5);

    // T2: 0xA5 with parity bit 1
    send_a(8'hA5, 1'b1, 1'b1, -1);
    check("t2_even_entry", last[0], 'h2A5);
    check("t2_odd_entry", last[2], 'h0A5);

    // T3: short idle glitch, then a frame with a one-clock glitch mid data bit 3
    n0 = npop[0];
    put(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    put(1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("t3_glitch_no_entry", npop[0] - n0, 0);
    send_a(8'h5A, 1'b0, 1'b1, 3);
    check("t3_vote_entry", last[0], 'h05A);

    // T4: line low for 12 bit times
    frame_model(0, 0, 1, 1'b0, 1'b1);
    frame_model(2, 0, 2, 1'b0, 1'b1);
    n0 = npop[0];
    put(1'b0, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    put(1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("t4_break_a", cnt_brk[0], exp_brk[0]);
    check("t4_break_c", cnt_brk[2], exp_brk[2]);
    check("t4_break_once", cnt_brk[0], 1);
    check("t4_no_entry", npop[0] - n0, 0);
    send_a(8'h3C, 1'b0, 1'b1, -1);
    check("t4_next_frame", last[0], 'h03C);

    // T5: consumer stalled, five frames into a four-entry FIFO
    rdy[0] = 1'b0;
    for (int v = 1; v <= 5; v++) send_a(v, even_pb(v), 1'b1, -1);
    check("t5_overrun_model", cnt_ovr[0], exp_ovr[0]);
    check("t5_overrun_once", cnt_ovr[0], 1);
    check("t5_held_valid", int'(valid_a), 1);
    check("t5_head_entry", int'(got[0]), 'h001);
    rdy[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_drained", q[0].size(), 0);
    check("t5_last_drained", last[0], 'h004);
    check("t5_odd_no_overrun", cnt_ovr[2], 0);

    // T6: 7N2, second stop bit low, then a clean frame
    send_b(7'h55, 1'b1, 1'b0);
    check("t6_frame_err_entry", last[1], 'h455);
    send_b(7'h2A, 1'b1, 1'b1);
    check("t6_clean_entry", last[1], 'h02A);
    check("t6_no_break", cnt_brk[1], exp_brk[1]);

    // Reset pulsed while receiving data bits, with one entry waiting in the FIFO
    rdy[0] = 1'b0;
    send_a(8'h77, 1'b0, 1'b1, -1);
    check("rst_prefill_valid", int'(valid_a), 1);
    hold_bit(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) hold_bit(1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", int'({valid_a, brk_a, ovr_a, perr_a, ferr_a, data_a}), 0);
    q[0].delete();
    q[2].delete();
    put(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("rst_fifo_empty", int'(valid_a), 0);
    rdy[0] = 1'b1;
    send_a(8'h3C, 1'b0, 1'b1, -1);
    check("rst_after_frame", last[0], 'h03C);
    check("final_queue_a", q[0].size(), 0);
    check("final_queue_c", q[2].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
